// File: rtl/picomem_arb_2_1.sv
// -----------------------------------------------------------------------------
// picomem_arb_2_1
//
// Two-master PicoMem bus arbiter. Master 0 is normally the picorv32 core and
// master 1 a DMA engine or debug loader; both share one PicoMem slave port that
// feeds the top-level 1:4 address mux.
//
// Grants are round-robin on ties and held for the whole transfer. The granted
// master's request fields reach the slave combinationally and the slave's
// ready/rdata return combinationally, so the only added latency is the single
// IDLE cycle in which a request is sampled. Every change of bus owner
// therefore costs exactly one idle bus cycle.
//
// Optional feature (macro PICOMEM_ARB_TIMEOUT_EN):
//   A 16-bit watchdog terminates a granted transfer whose slave has not
//   answered after TIMEOUT_CYCLES cycles. The master then sees ready with
//   TIMEOUT_RDATA and timeout_pulse strobes for one cycle. Without the macro
//   no counter exists, timeout_pulse is tied low and a hung slave keeps the
//   grant indefinitely.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles a granted transfer may wait for picos_ready (1..65535)
//   TIMEOUT_RDATA   read data returned on a watchdog-terminated transfer
//
// Ports:
//   core_clk        sole clock, rising edge
//   resetn          asynchronous active-low reset
//   picom0_*        master 0: valid/addr/wdata/wstrb in, ready/rdata out
//   picom1_*        master 1: same as master 0
//   picos_*         slave: valid/addr/wdata/wstrb out, ready/rdata in
//   timeout_pulse   one-cycle strobe when the watchdog ends a transfer
// -----------------------------------------------------------------------------
module picomem_arb_2_1 #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hBADB_AD00
) (
  input  logic        core_clk,
  input  logic        resetn,

  input  logic        picom0_valid,
  output logic        picom0_ready,
  input  logic [31:0] picom0_addr,
  input  logic [31:0] picom0_wdata,
  input  logic [3:0]  picom0_wstrb,
  output logic [31:0] picom0_rdata,

  input  logic        picom1_valid,
  output logic        picom1_ready,
  input  logic [31:0] picom1_addr,
  input  logic [31:0] picom1_wdata,
  input  logic [3:0]  picom1_wstrb,
  output logic [31:0] picom1_rdata,

  output logic        picos_valid,
  input  logic        picos_ready,
  output logic [31:0] picos_addr,
  output logic [31:0] picos_wdata,
  output logic [3:0]  picos_wstrb,
  input  logic [31:0] picos_rdata,

  output logic        timeout_pulse
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_param_check
    $error("picomem_arb_2_1: TIMEOUT_CYCLES must lie in 1..65535");
  end

  // Round-robin pick from IDLE. 'last' names the master that completed most
  // recently; on a tie the other one wins. Returns the next state.
  function automatic logic [1:0] pick_master(input logic v0,
                                             input logic v1,
                                             input logic last);
    logic [1:0] nxt;
    nxt = ST_IDLE;
    if (v0 && v1) begin
      nxt = last ? ST_GNT0 : ST_GNT1;
    end else if (v0) begin
      nxt = ST_GNT0;
    end else if (v1) begin
      nxt = ST_GNT1;
    end
    return nxt;
  endfunction

  logic [1:0] state_p0;
  logic [1:0] state_nxt;
  logic       last_p0;
  logic       last_nxt;

  logic       gnt0;
  logic       gnt1;
  logic       sel_valid;
  logic       expire;

  assign gnt0      = (state_p0 == ST_GNT0);
  assign gnt1      = (state_p0 == ST_GNT1);
  assign sel_valid = (gnt0 & picom0_valid) | (gnt1 & picom1_valid);

`ifdef PICOMEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] wdog_cnt_p0;

  // A slave answer in the expiry cycle wins: expiry requires picos_ready low.
  assign expire = sel_valid & ~picos_ready & (wdog_cnt_p0 == TIMEOUT_LIMIT);

  // Watchdog stage: every grant is entered from IDLE, so holding the counter
  // at zero in IDLE clears it on entry to GNTn.
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      wdog_cnt_p0 <= '0;
    end else if (state_p0 == ST_IDLE) begin
      wdog_cnt_p0 <= '0;
    end else if (!picos_ready) begin
      wdog_cnt_p0 <= wdog_cnt_p0 + 16'd1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // Next-state and round-robin pointer.
  always_comb begin
    state_nxt = state_p0;
    last_nxt  = last_p0;
    case (state_p0)
      ST_IDLE: begin
        state_nxt = pick_master(picom0_valid, picom1_valid, last_p0);
      end
      ST_GNT0: begin
        if (!picom0_valid) begin
          // Master withdrew its request: release without touching 'last'.
          state_nxt = ST_IDLE;
        end else if (picos_ready || expire) begin
          state_nxt = ST_IDLE;
          last_nxt  = 1'b0;
        end
      end
      ST_GNT1: begin
        if (!picom1_valid) begin
          state_nxt = ST_IDLE;
        end else if (picos_ready || expire) begin
          state_nxt = ST_IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Arbitration stage: reset parks the bus in IDLE with master 0 favoured.
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      state_p0 <= ST_IDLE;
      last_p0  <= 1'b1;
    end else begin
      state_p0 <= state_nxt;
      last_p0  <= last_nxt;
    end
  end

  // Forward the granted master's request; all zero while nobody owns the bus.
  always_comb begin
    picos_valid = 1'b0;
    picos_addr  = '0;
    picos_wdata = '0;
    picos_wstrb = '0;
    if (gnt0) begin
      picos_valid = picom0_valid & ~expire;
      picos_addr  = picom0_addr;
      picos_wdata = picom0_wdata;
      picos_wstrb = picom0_wstrb;
    end else if (gnt1) begin
      picos_valid = picom1_valid & ~expire;
      picos_addr  = picom1_addr;
      picos_wdata = picom1_wdata;
      picos_wstrb = picom1_wstrb;
    end
  end

  // Ready is qualified by the master's own valid so a withdrawn request never
  // sees a completion.
  assign picom0_ready = gnt0 & picom0_valid & (picos_ready | expire);
  assign picom1_ready = gnt1 & picom1_valid & (picos_ready | expire);

  assign picom0_rdata = !gnt0 ? 32'd0 : (expire ? TIMEOUT_RDATA : picos_rdata);
  assign picom1_rdata = !gnt1 ? 32'd0 : (expire ? TIMEOUT_RDATA : picos_rdata);

  assign timeout_pulse = expire;

endmodule

// File: tb/tb_picomem_arb_2_1.sv
module tb_picomem_arb_2_1;

  logic        core_clk = 1'b0;
  logic        resetn;
  logic        picom0_valid;
  logic        picom0_ready;
  logic [31:0] picom0_addr;
  logic [31:0] picom0_wdata;
  logic [3:0]  picom0_wstrb;
  logic [31:0] picom0_rdata;
  logic        picom1_valid;
  logic        picom1_ready;
  logic [31:0] picom1_addr;
  logic [31:0] picom1_wdata;
  logic [3:0]  picom1_wstrb;
  logic [31:0] picom1_rdata;
  logic        picos_valid;
  logic        picos_ready;
  logic [31:0] picos_addr;
  logic [31:0] picos_wdata;
  logic [3:0]  picos_wstrb;
  logic [31:0] picos_rdata;
  logic        timeout_pulse;

  always #5 core_clk = ~core_clk;

  picomem_arb_2_1 #(
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_RDATA (32'hBADB_AD00)
  ) dut (
    .core_clk     (core_clk),
    .resetn       (resetn),
    .picom0_valid (picom0_valid),
    .picom0_ready (picom0_ready),
    .picom0_addr  (picom0_addr),
    .picom0_wdata (picom0_wdata),
    .picom0_wstrb (picom0_wstrb),
    .picom0_rdata (picom0_rdata),
    .picom1_valid (picom1_valid),
    .picom1_ready (picom1_ready),
    .picom1_addr  (picom1_addr),
    .picom1_wdata (picom1_wdata),
    .picom1_wstrb (picom1_wstrb),
    .picom1_rdata (picom1_rdata),
    .picos_valid  (picos_valid),
    .picos_ready  (picos_ready),
    .picos_addr   (picos_addr),
    .picos_wdata  (picos_wdata),
    .picos_wstrb  (picos_wstrb),
    .picos_rdata  (picos_rdata),
    .timeout_pulse(timeout_pulse)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        pulse;
    int          at;
  } exp_t;

  req_t mq0[$];
  req_t mq1[$];
  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  logic slv_hang;
  int   slv_delay;
  int   slv_cnt;
  logic slv_busy;

  always @(posedge core_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    if (a == 32'h4000_0010) return 32'h1234_5678;
    return ~a;
  endfunction

  task automatic req_push(input int m, input logic [31:0] a, input logic [31:0] w,
                          input logic [3:0] s);
    req_t r;
    r.addr = a; r.wdata = w; r.wstrb = s;
    if (m == 0) mq0.push_back(r);
    else        mq1.push_back(r);
  endtask

  task automatic exp_push(input int m, input logic [31:0] a, input logic [31:0] w,
                          input logic [3:0] s, input logic [31:0] rd,
                          input logic p, input int at);
    exp_t e;
    e.m = m; e.addr = a; e.wdata = w; e.wstrb = s;
    e.rdata = rd; e.pulse = p; e.at = at;
    exp_q.push_back(e);
  endtask

  // One bus cycle: masters drop after their ready and load the next queued
  // request, then the slave model decides on this cycle's answer.
  task automatic step();
    logic d0, d1;
    req_t r;
    @(negedge core_clk);
    d0 = picom0_ready;
    d1 = picom1_ready;
    @(posedge core_clk);
    #1;
    if (d0) begin
      picom0_valid = 1'b0; picom0_addr = '0; picom0_wdata = '0; picom0_wstrb = '0;
    end
    if (!picom0_valid && mq0.size() > 0) begin
      r = mq0.pop_front();
      picom0_valid = 1'b1; picom0_addr = r.addr; picom0_wdata = r.wdata; picom0_wstrb = r.wstrb;
    end
    if (d1) begin
      picom1_valid = 1'b0; picom1_addr = '0; picom1_wdata = '0; picom1_wstrb = '0;
    end
    if (!picom1_valid && mq1.size() > 0) begin
      r = mq1.pop_front();
      picom1_valid = 1'b1; picom1_addr = r.addr; picom1_wdata = r.wdata; picom1_wstrb = r.wstrb;
    end
    #1;
    if (slv_hang || !(picos_valid || slv_busy)) begin
      picos_ready = 1'b0; slv_busy = 1'b0; slv_cnt = 0;
    end else if (slv_cnt >= slv_delay) begin
      picos_ready = 1'b1; picos_rdata = slv_rd(picos_addr); slv_busy = 1'b0; slv_cnt = 0;
    end else begin
      picos_ready = 1'b0; slv_busy = 1'b1; slv_cnt++;
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_picos_valid"}, 32'(picos_valid), 32'd0);
    chk({tag, "_picos_addr"},  picos_addr, 32'd0);
    chk({tag, "_picos_wdata"}, picos_wdata, 32'd0);
    chk({tag, "_picos_wstrb"}, 32'(picos_wstrb), 32'd0);
    chk({tag, "_m0_ready"},    32'(picom0_ready), 32'd0);
    chk({tag, "_m1_ready"},    32'(picom1_ready), 32'd0);
    chk({tag, "_m0_rdata"},    picom0_rdata, 32'd0);
    chk({tag, "_m1_rdata"},    picom1_rdata, 32'd0);
    chk({tag, "_pulse"},       32'(timeout_pulse), 32'd0);
  endtask

  // Monitor: every master ready is matched against the head of the queue.
  always @(negedge core_clk) begin
    if (resetn) begin
      if (picom0_ready || picom1_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", {30'd0, picom1_ready, picom0_ready}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("single_ready", 32'(picom0_ready & picom1_ready), 32'd0);
          chk("ready_master", picom1_ready ? 32'd1 : 32'd0, 32'(mon_e.m));
          chk("rdata", (mon_e.m == 0) ? picom0_rdata : picom1_rdata, mon_e.rdata);
          chk("other_rdata", (mon_e.m == 0) ? picom1_rdata : picom0_rdata, 32'd0);
          chk("timeout_pulse", 32'(timeout_pulse), 32'(mon_e.pulse));
          if (mon_e.at >= 0) chk("ready_cycle", 32'(cyc - t0), 32'(mon_e.at));
          if (mon_e.pulse) begin
            chk("slave_valid_cut", 32'(picos_valid), 32'd0);
          end else begin
            chk("slave_valid", 32'(picos_valid), 32'd1);
            chk("slave_addr", picos_addr, mon_e.addr);
            chk("slave_wdata", picos_wdata, mon_e.wdata);
            chk("slave_wstrb", 32'(picos_wstrb), 32'(mon_e.wstrb));
          end
        end
      end else begin
        chk("pulse_without_ready", 32'(timeout_pulse), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    resetn = 1'b0;
    slv_hang = 1'b0; slv_delay = 0; slv_cnt = 0; slv_busy = 1'b0;
    picom0_valid = 1'b1; picom0_addr = 32'h1111_1111; picom0_wdata = 32'h2222_2222; picom0_wstrb = 4'hF;
    picom1_valid = 1'b1; picom1_addr = 32'h3333_3333; picom1_wdata = 32'h4444_4444; picom1_wstrb = 4'hF;
    picos_ready = 1'b1; picos_rdata = 32'hFFFF_FFFF;

    // Reset holds IDLE even with both masters and the slave active.
    repeat (2) @(posedge core_clk);
    #2;
    chk_outputs_zero("por");
    picom0_valid = 1'b0; picom0_addr = '0; picom0_wdata = '0; picom0_wstrb = '0;
    picom1_valid = 1'b0; picom1_addr = '0; picom1_wdata = '0; picom1_wstrb = '0;
    picos_ready = 1'b0; picos_rdata = '0;
    resetn = 1'b1;

    // Reset in the middle of a GNT0 transfer, then a clean read.
    slv_hang = 1'b1;
    req_push(0, 32'h4000_0010, 32'd0, 4'h0);
    step();
    step();
    chk("gnt0_valid", 32'(picos_valid), 32'd1);
    chk("gnt0_addr", picos_addr, 32'h4000_0010);
    #1 resetn = 1'b0;
    #1 chk_outputs_zero("async_rst");
    step();
    chk("rst_held_idle", 32'(picos_valid), 32'd0);
    slv_hang = 1'b0; slv_delay = 0; slv_busy = 1'b0;
    resetn = 1'b1;
    t0 = cyc;
    exp_push(0, 32'h4000_0010, 32'd0, 4'h0, 32'h1234_5678, 1'b0, 1);
    #2 chk("idle_after_release", 32'(picos_valid), 32'd0);
    drain(10);

    // Single master-1 write, slave answers three cycles after the grant.
    slv_delay = 3;
    req_push(1, 32'h8200_0000, 32'hCAFE_F00D, 4'b1111);
    exp_push(1, 32'h8200_0000, 32'hCAFE_F00D, 4'b1111, 32'h7DFF_FFFF, 1'b0, 4);
    step();
    t0 = cyc;
    drain(20);

    // Withdrawn request: last stays 1, so master 0 still wins the next tie.
    slv_hang = 1'b1;
    req_push(0, 32'h3000_0000, 32'd0, 4'h0);
    step();
    step();
    picom0_valid = 1'b0;
    slv_hang = 1'b0; slv_delay = 0;
    req_push(0, 32'h3000_0004, 32'h0000_0055, 4'b0001);
    req_push(1, 32'h3000_0008, 32'h0000_00AA, 4'b1000);
    exp_push(0, 32'h3000_0004, 32'h0000_0055, 4'b0001, 32'hCFFF_FFFB, 1'b0, 1);
    exp_push(1, 32'h3000_0008, 32'h0000_00AA, 4'b1000, 32'hCFFF_FFF7, 1'b0, 3);
    step();
    t0 = cyc;
    drain(20);

    // Fresh reset, both masters streaming: grants alternate 0,1,0,1...
    #1 resetn = 1'b0;
    step();
    resetn = 1'b1;
    slv_delay = 1;
    for (int r = 0; r < 8; r++) begin
      req_push(0, 32'h1000_0000 + 32'(r * 16), 32'h0A00_0000 + 32'(r), 4'b0011);
      req_push(1, 32'h2000_0000 + 32'(r * 16), 32'h0B00_0000 + 32'(r), 4'b1100);
    end
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0)
        exp_push(0, 32'h1000_0000 + 32'((i / 2) * 16), 32'h0A00_0000 + 32'(i / 2), 4'b0011,
                 ~(32'h1000_0000 + 32'((i / 2) * 16)), 1'b0, 2 + 3 * i);
      else
        exp_push(1, 32'h2000_0000 + 32'((i / 2) * 16), 32'h0B00_0000 + 32'(i / 2), 4'b1100,
                 ~(32'h2000_0000 + 32'((i / 2) * 16)), 1'b0, 2 + 3 * i);
    end
    step();
    t0 = cyc;
    drain(80);

    // Master 0 re-requests at once while master 1 waits behind it.
    slv_delay = 2;
    req_push(0, 32'h6000_0000, 32'h6000_AAAA, 4'hF);
    req_push(0, 32'h6000_0004, 32'h6000_BBBB, 4'hF);
    req_push(0, 32'h6000_0008, 32'h6000_CCCC, 4'hF);
    exp_push(0, 32'h6000_0000, 32'h6000_AAAA, 4'hF, 32'h9FFF_FFFF, 1'b0, 3);
    exp_push(1, 32'h7000_0000, 32'h7000_DDDD, 4'h3, 32'h8FFF_FFFF, 1'b0, 7);
    exp_push(0, 32'h6000_0004, 32'h6000_BBBB, 4'hF, 32'h9FFF_FFFB, 1'b0, 11);
    exp_push(0, 32'h6000_0008, 32'h6000_CCCC, 4'hF, 32'h9FFF_FFF7, 1'b0, 15);
    step();
    t0 = cyc;
    req_push(1, 32'h7000_0000, 32'h7000_DDDD, 4'h3);
    drain(40);

`ifdef PICOMEM_ARB_TIMEOUT_EN
    // Silent slave: expiry on the fifth GNT0 cycle.
    slv_hang = 1'b1;
    req_push(0, 32'h5000_0000, 32'd0, 4'h0);
    exp_push(0, 32'h5000_0000, 32'd0, 4'h0, 32'hBADB_AD00, 1'b1, 5);
    step();
    t0 = cyc;
    drain(20);
    slv_hang = 1'b0;
    // Slave answers in the expiry cycle: slave data, no pulse.
    slv_delay = 4;
    req_push(1, 32'h5000_0100, 32'h1111_2222, 4'hF);
    exp_push(1, 32'h5000_0100, 32'h1111_2222, 4'hF, 32'hAFFF_FEFF, 1'b0, 5);
    step();
    t0 = cyc;
    drain(20);
`else
    // Without the watchdog a silent slave keeps the grant.
    slv_hang = 1'b1;
    req_push(0, 32'h5000_0000, 32'd0, 4'h0);
    exp_push(0, 32'h5000_0000, 32'd0, 4'h0, 32'hAFFF_FFFF, 1'b0, -1);
    step();
    repeat (20) step();
    chk("hung_grant_valid", 32'(picos_valid), 32'd1);
    chk("hung_grant_ready", 32'(picom0_ready), 32'd0);
    slv_hang = 1'b0; slv_delay = 0;
    drain(10);
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
